// File: rtl/hmac_stream_if.sv
// Handshake channel between the HMAC controller and the external SHA3 sponge core.
interface hmac_stream_if #(
  parameter int RATE     = 1088,
  parameter int DIGEST_W = 256
);
  logic [RATE-1:0]     h_in;
  logic                h_more;
  logic                h_valid;
  logic [DIGEST_W-1:0] h_digest;
  logic                h_next;
  logic                h_done;

  modport master (output h_in, h_more, h_valid, input h_digest, h_next, h_done);
  modport slave  (input h_in, h_more, h_valid, output h_digest, h_next, h_done);
endinterface

// File: rtl/hmac_stream.sv
// HMAC-SHA3 sequencer: key^ipad, streamed message blocks, key^opad, then the
// padded inner digest; the core's second digest becomes the MAC.
module hmac_stream #(
  parameter int RATE     = 1088,
  parameter int DIGEST_W = 256,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [RATE-1:0]     key,
  input  logic [RATE-1:0]     msg_block,
  input  logic                msg_valid,
  input  logic                msg_last,
  output logic                msg_ready,
  hmac_stream_if.master       core,
  output logic [DIGEST_W-1:0] mac,
  output logic                done,
  output logic                busy,
  output logic [CNT_W-1:0]    blk_count
);
  localparam logic [RATE-1:0] IPAD = {(RATE/8){8'h36}};
  localparam logic [RATE-1:0] OPAD = {(RATE/8){8'h5c}};

  typedef enum logic [2:0] {IDLE, IKEY, IMSG, IWAIT, OKEY, OFIN, OWAIT} state_t;

  state_t              state, state_d;
  logic [RATE-1:0]     key_r, key_d;
  logic [DIGEST_W-1:0] dig_r, dig_d;
  logic [RATE-1:0]     h_in_r, h_in_d;
  logic                h_more_r, h_more_d;
  logic                h_valid_r, h_valid_d;
  logic                msg_ready_d, done_d, busy_d;
  logic [DIGEST_W-1:0] mac_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [RATE-1:0]     fin_block;
  logic                accept, next_ev;

  assign core.h_in    = h_in_r;
  assign core.h_more  = h_more_r;
  assign core.h_valid = h_valid_r;

  // h_done wins over a coincident h_next.
  assign accept  = msg_valid & msg_ready;
  assign next_ev = core.h_next & ~core.h_done;

  // Outer final block: inner digest in the MSBs, SHA3 domain/pad bytes around the zero fill.
  always_comb begin
    fin_block = '0;
    fin_block[RATE-1 -: DIGEST_W]      = dig_r;
    fin_block[RATE-DIGEST_W-1 -: 8]    = 8'h06;
    fin_block[7:0]                     = 8'h80;
  end

  always_comb begin
    state_d     = state;
    key_d       = key_r;
    dig_d       = dig_r;
    h_in_d      = h_in_r;
    h_more_d    = h_more_r;
    h_valid_d   = 1'b0;
    msg_ready_d = msg_ready;
    mac_d       = mac;
    done_d      = 1'b0;
    cnt_d       = blk_count;
    case (state)
      IDLE: if (start) begin
        key_d     = key;
        cnt_d     = '0;
        h_in_d    = key ^ IPAD;
        h_more_d  = 1'b1;
        h_valid_d = 1'b1;
        state_d   = IKEY;
      end
      IKEY: if (next_ev) begin
        msg_ready_d = 1'b1;
        state_d     = IMSG;
      end
      IMSG: begin
        if (accept) begin
          msg_ready_d = 1'b0;
          h_in_d      = msg_block;
          h_more_d    = ~msg_last;
          h_valid_d   = 1'b1;
          if (blk_count != '1) cnt_d = blk_count + 1'b1;
          if (msg_last) state_d = IWAIT;
        end else if (!msg_ready && next_ev) begin
          msg_ready_d = 1'b1;
        end
      end
      IWAIT: if (core.h_done) begin
        dig_d     = core.h_digest;
        h_in_d    = key_r ^ OPAD;
        h_more_d  = 1'b1;
        h_valid_d = 1'b1;
        state_d   = OKEY;
      end
      OKEY: if (next_ev) begin
        h_in_d    = fin_block;
        h_more_d  = 1'b0;
        h_valid_d = 1'b1;
        state_d   = OFIN;
      end
      OFIN: state_d = OWAIT;
      OWAIT: if (core.h_done) begin
        mac_d   = core.h_digest;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_r     <= '0;
      dig_r     <= '0;
      h_in_r    <= '0;
      h_more_r  <= 1'b0;
      h_valid_r <= 1'b0;
      msg_ready <= 1'b0;
      mac       <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      blk_count <= '0;
    end else begin
      state     <= state_d;
      key_r     <= key_d;
      dig_r     <= dig_d;
      h_in_r    <= h_in_d;
      h_more_r  <= h_more_d;
      h_valid_r <= h_valid_d;
      msg_ready <= msg_ready_d;
      mac       <= mac_d;
      done      <= done_d;
      busy      <= busy_d;
      blk_count <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hmac_stream.sv
// Directed bench: the bench plays the SHA3 core by hand, supplying chosen digests
// and checking every block the controller issues against hand-built expectations.
module tb_hmac_stream;
  localparam logic [1087:0] IPAD_A = {136{8'h36}};
  localparam logic [1087:0] OPAD_A = {136{8'h5c}};
  localparam logic [575:0]  IPAD_B = {72{8'h36}};
  localparam logic [575:0]  OPAD_B = {72{8'h5c}};

  logic clk, rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   run_id   = 0;
  logic [255:0] exp_mac = '0;

  // 1088/256 instance
  logic          start_a, msg_valid_a, msg_last_a, msg_ready_a, done_a, busy_a;
  logic [1087:0] key_a, msg_block_a;
  logic [255:0]  mac_a;
  logic [15:0]   blk_count_a;
  hmac_stream_if #(.RATE(1088), .DIGEST_W(256)) ca ();

  hmac_stream #(.RATE(1088), .DIGEST_W(256), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .key(key_a), .msg_block(msg_block_a),
    .msg_valid(msg_valid_a), .msg_last(msg_last_a), .msg_ready(msg_ready_a),
    .core(ca), .mac(mac_a), .done(done_a), .busy(busy_a), .blk_count(blk_count_a));

  // 576/512 instance
  logic          start_b, msg_valid_b, msg_last_b, msg_ready_b, done_b, busy_b;
  logic [575:0]  key_b, msg_block_b;
  logic [511:0]  mac_b;
  logic [15:0]   blk_count_b;
  hmac_stream_if #(.RATE(576), .DIGEST_W(512)) cb ();

  hmac_stream #(.RATE(576), .DIGEST_W(512), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .key(key_b), .msg_block(msg_block_b),
    .msg_valid(msg_valid_b), .msg_last(msg_last_b), .msg_ready(msg_ready_b),
    .core(cb), .mac(mac_b), .done(done_b), .busy(busy_b), .blk_count(blk_count_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [1087:0] obs, input logic [1087:0] exp);
    chk({tag, "[hi]"},  obs[1087:576], exp[1087:576]);
    chk({tag, "[mid]"}, obs[575:64],   exp[575:64]);
    chk({tag, "[lo]"},  obs[63:0],     exp[63:0]);
  endtask

  task automatic pulse_next_a();
    ca.h_next = 1'b1;
    tick();
    ca.h_next = 1'b0;
  endtask

  // One full MAC on instance A. gap: idle cycles before each block; spur: stray
  // start in IMSG and stray h_next in IWAIT; abort: reset in OWAIT; b2b: return
  // in the done cycle so the caller can start again immediately.
  task automatic run_a(input logic [1087:0] k, input int nblk, input int gap,
                       input bit spur, input bit abort, input bit b2b);
    logic [1087:0] blk;
    logic [255:0]  din, dout;
    run_id++;
    din  = {8{32'h1a00_0000 + 32'(run_id)}};
    dout = {8{32'hd000_0000 + 32'(run_id * 16 + nblk)}};

    start_a = 1'b1; key_a = k;
    tick();
    start_a = 1'b0; key_a = ~k;
    chk("ikey_valid", ca.h_valid, 1);
    chk_blk("ikey_in", ca.h_in, k ^ IPAD_A);
    chk("ikey_more", ca.h_more, 1);
    chk("busy_rise", busy_a, 1);
    chk("cnt_clear", blk_count_a, 0);
    chk("done_low", done_a, 0);
    chk("mac_held", mac_a, exp_mac);
    tick();
    chk("valid_one_cycle", ca.h_valid, 0);
    pulse_next_a();
    chk("ready_rise", msg_ready_a, 1);

    for (int i = 0; i < nblk; i++) begin
      blk = {34{32'hb000_0000 + 32'(i * 256 + run_id)}};
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_ready", msg_ready_a, 1);
        chk("gap_valid", ca.h_valid, 0);
      end
      if (spur && i == 0) begin
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("spur_start", ca.h_valid, 0);
      end
      msg_block_a = blk; msg_valid_a = 1'b1; msg_last_a = (i == nblk - 1);
      tick();
      msg_valid_a = 1'b0; msg_last_a = 1'b0;
      chk("msg_valid", ca.h_valid, 1);
      chk_blk("msg_in", ca.h_in, blk);
      chk("msg_more", ca.h_more, (i != nblk - 1));
      chk("ready_fall", msg_ready_a, 0);
      chk("blk_count", blk_count_a, i + 1);
      if (i != nblk - 1) begin
        msg_block_a = ~blk; msg_valid_a = 1'b1;
        tick();
        msg_valid_a = 1'b0;
        chk("held_ready", msg_ready_a, 0);
        chk("held_valid", ca.h_valid, 0);
        chk("held_count", blk_count_a, i + 1);
        pulse_next_a();
        chk("ready_again", msg_ready_a, 1);
      end
    end

    if (spur) begin
      pulse_next_a();
      chk("spur_next", ca.h_valid, 0);
    end
    ca.h_digest = din; ca.h_done = 1'b1;
    tick();
    ca.h_done = 1'b0;
    chk("okey_valid", ca.h_valid, 1);
    chk_blk("okey_in", ca.h_in, k ^ OPAD_A);
    chk("okey_more", ca.h_more, 1);
    tick();
    pulse_next_a();
    chk("ofin_valid", ca.h_valid, 1);
    chk_blk("ofin_in", ca.h_in, {din, 8'h06, 816'b0, 8'h80});
    chk("ofin_more", ca.h_more, 0);
    tick();
    chk("owait_valid", ca.h_valid, 0);
    chk("owait_busy", busy_a, 1);

    if (abort) begin
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", busy_a, 0);
      chk("rst_valid", ca.h_valid, 0);
      chk("rst_done", done_a, 0);
      chk("rst_mac", mac_a, 0);
      chk("rst_ready", msg_ready_a, 0);
      chk("rst_cnt", blk_count_a, 0);
      chk_blk("rst_hin", ca.h_in, '0);
      exp_mac = '0;
      tick();
      chk("rst_no_done", done_a, 0);
      rst = 1'b0;
      tick();
      return;
    end

    ca.h_digest = dout; ca.h_done = 1'b1;
    tick();
    ca.h_done = 1'b0;
    chk("done_pulse", done_a, 1);
    chk("mac_out", mac_a, dout);
    chk("busy_fall", busy_a, 0);
    chk("final_count", blk_count_a, nblk);
    exp_mac = dout;
    if (!b2b) begin
      tick();
      chk("done_one_cycle", done_a, 0);
      chk("mac_stays", mac_a, dout);
    end
  endtask

  task automatic run_b();
    logic [575:0] k, blk;
    logic [511:0] din, dout;
    k    = {24'h6b6579, 552'b0};
    blk  = {8'h06, 560'b0, 8'h80};
    din  = {16{32'h5151_0000 + 32'h3}};
    dout = {16{32'h7e7e_0000 + 32'h9}};
    start_b = 1'b1; key_b = k;
    tick();
    start_b = 1'b0; key_b = '0;
    chk_blk("b_ikey_in", {512'b0, ca.h_valid ? cb.h_in : cb.h_in}, {512'b0, k ^ IPAD_B});
    chk("b_ikey_valid", cb.h_valid, 1);
    cb.h_next = 1'b1;
    tick();
    cb.h_next = 1'b0;
    chk("b_ready", msg_ready_b, 1);
    msg_block_b = blk; msg_valid_b = 1'b1; msg_last_b = 1'b1;
    tick();
    msg_valid_b = 1'b0; msg_last_b = 1'b0;
    chk_blk("b_msg_in", {512'b0, cb.h_in}, {512'b0, blk});
    chk("b_msg_more", cb.h_more, 0);
    cb.h_digest = din; cb.h_done = 1'b1;
    tick();
    cb.h_done = 1'b0;
    chk_blk("b_okey_in", {512'b0, cb.h_in}, {512'b0, k ^ OPAD_B});
    cb.h_next = 1'b1;
    tick();
    cb.h_next = 1'b0;
    chk("b_ofin_valid", cb.h_valid, 1);
    chk_blk("b_ofin_in", {512'b0, cb.h_in}, {512'b0, din, 8'h06, 48'b0, 8'h80});
    chk("b_ofin_more", cb.h_more, 0);
    tick();
    cb.h_digest = dout; cb.h_done = 1'b1;
    tick();
    cb.h_done = 1'b0;
    chk("b_done", done_b, 1);
    chk("b_mac", mac_b, dout);
    chk("b_count", blk_count_b, 1);
    tick();
    chk("b_done_low", done_b, 0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 0; key_a = '0; msg_block_a = '0; msg_valid_a = 0; msg_last_a = 0;
    start_b = 0; key_b = '0; msg_block_b = '0; msg_valid_b = 0; msg_last_b = 0;
    ca.h_digest = '0; ca.h_next = 0; ca.h_done = 0;
    cb.h_digest = '0; cb.h_next = 0; cb.h_done = 0;
    tick();
    tick();
    chk("reset_ready", msg_ready_a, 0);
    chk_blk("reset_hin", ca.h_in, '0);
    chk("reset_more", ca.h_more, 0);
    chk("reset_valid", ca.h_valid, 0);
    chk("reset_mac", mac_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_cnt", blk_count_a, 0);
    rst = 1'b0;
    tick();

    run_a({24'h6b6579, 1064'b0}, 1, 0, 0, 0, 0);
    run_a({24'h6b6579, 1064'b0}, 3, 2, 0, 0, 0);
    run_a({24'h6b6579, 1064'b0}, 2, 0, 1, 0, 0);
    run_a({32'hcafe_f00d, 1056'b0}, 1, 0, 0, 0, 1);
    run_a({24'h6b6579, 1064'b0}, 2, 1, 0, 0, 0);
    run_a({24'h6b6579, 1064'b0}, 1, 0, 0, 1, 0);
    run_a({24'h6b6579, 1064'b0}, 1, 0, 0, 0, 0);
    run_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
